// File: rtl/result_uart_tx.sv
// Result readback transmitter: fetches OUT_SIZE words from the result BRAM and sends them 8N1.
// Define RESULT_TX_CHECKSUM_EN to append an XOR checksum frame after the last data byte.
module result_uart_tx #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OUT_SIZE     = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  tx
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned ByteW = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0]       CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [ByteW-1:0]      LastByte = ByteW'(Bytes - 1);
  localparam logic [ADDR_WIDTH-1:0] LastWord = ADDR_WIDTH'(OUT_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
    StStop,
    StDone
`ifdef RESULT_TX_CHECKSUM_EN
    ,
    StCsum
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [3:0]              bit_q, bit_d;
  logic [ByteW-1:0]        byte_q, byte_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic                    tick;

`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  function automatic logic [7:0] fold_bytes(input logic [DATA_WIDTH-1:0] w);
    logic [7:0] f;
    f = '0;
    for (int i = 0; i < int'(Bytes); i++) begin
      f = f ^ w[8*i +: 8];
    end
    return f;
  endfunction
`endif

  assign tick    = (cnt_q == '0);
  assign rd_addr = addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    word_d  = word_q;
`ifdef RESULT_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    tx      = 1'b1;
    busy    = 1'b1;
    done    = 1'b0;
    rd_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          state_d = StFetch;
          addr_d  = '0;
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      StFetch: begin
        rd_en   = 1'b1;
        state_d = StLoad;
      end

      StLoad: begin
        word_d  = rd_data;
        byte_d  = '0;
        cnt_d   = CntMax;
        state_d = StStart;
`ifdef RESULT_TX_CHECKSUM_EN
        csum_d  = csum_q ^ fold_bytes(rd_data);
`endif
      end

      StStart: begin
        tx = 1'b0;
        if (tick) begin
          cnt_d   = CntMax;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StData: begin
        // The word register shifts one bit per data bit, so the next byte lands in [7:0].
        tx = word_q[0];
        if (tick) begin
          cnt_d  = CntMax;
          word_d = word_q >> 1;
          if (bit_q == 4'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StStop: begin
        if (tick) begin
          cnt_d = CntMax;
          if (byte_q != LastByte) begin
            byte_d  = byte_q + 1'b1;
            state_d = StStart;
          end else if (addr_q != LastWord) begin
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end else begin
`ifdef RESULT_TX_CHECKSUM_EN
            bit_d   = '0;
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef RESULT_TX_CHECKSUM_EN
      StCsum: begin
        // Whole checksum frame in one state: bit 0 start, 1..8 data, 9 stop.
        if (bit_q == 4'd0) begin
          tx = 1'b0;
        end else if (bit_q == 4'd9) begin
          tx = 1'b1;
        end else begin
          tx = csum_q[0];
        end
        if (tick) begin
          cnt_d = CntMax;
          if (bit_q != 4'd0 && bit_q != 4'd9) begin
            csum_d = csum_q >> 1;
          end
          if (bit_q == 4'd9) begin
            state_d = StDone;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      addr_q  <= '0;
      word_q  <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: OUT_SIZE=2, CLKS_PER_BIT=4, two-word result BRAM model.
module tb_result_uart_tx;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned OS  = 2;
  localparam int unsigned CPB = 4;
  localparam int          MaxCyc = 800;

`ifdef RESULT_TX_CHECKSUM_EN
  localparam int NFr    = 9;
  localparam int DoneAt = 365;
`else
  localparam int NFr    = 8;
  localparam int DoneAt = 325;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rd_en, tx;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] mem [0:3];
  logic [7:0]    exp_bytes [0:8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h00, 8'hA5, 8'hA5,
                                     8'hFB};

  logic          tx_log   [0:MaxCyc];
  logic          busy_log [0:MaxCyc];
  logic          done_log [0:MaxCyc];
  logic          rden_log [0:MaxCyc];
  logic [AW-1:0] addr_log [0:MaxCyc];
  logic [7:0]    dec_q [$];

  int checks = 0;
  int errors = 0;

  result_uart_tx #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .OUT_SIZE    (OS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr[1:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle n is the one following the n-th clock edge after start is first applied.
  task automatic capture(input int ncyc, input bit hold, input int p1, input int p2,
                         input int rst_at);
    for (int n = 0; n < ncyc; n++) begin
      start = (n == 0) || hold || (n == p1) || (n == p2);
      rst   = (n == rst_at);
      @(posedge clk);
      #1;
      tx_log[n+1]   = tx;
      busy_log[n+1] = busy;
      done_log[n+1] = done;
      rden_log[n+1] = rd_en;
      addr_log[n+1] = rd_addr;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  function automatic logic exp_tx(input int t);
    logic       r;
    int         s;
    int         b;
    logic [7:0] v;
    r = 1'b1;
    for (int f = 0; f < NFr; f++) begin
      s = (f < 8) ? 3 + 162 * (f / 4) + 40 * (f % 4) : 325;
      if (t >= s && t < s + 40) begin
        b = (t - s) / 4;
        v = exp_bytes[f];
        if (b == 0) r = 1'b0;
        else if (b == 9) r = 1'b1;
        else r = v[b-1];
      end
    end
    return r;
  endfunction

  task automatic decode(input int from, input int to);
    int         t;
    logic [7:0] v;
    dec_q.delete();
    t = from;
    while (t + 39 <= to) begin
      if (tx_log[t] == 1'b0) begin
        for (int j = 0; j < 8; j++) v[j] = tx_log[t + 4 * (j + 1) + 2];
        dec_q.push_back(v);
        t += 40;
      end else begin
        t++;
      end
    end
  endtask

  task automatic check_stream(input string tag, input int off);
    int bad;
    bad = 0;
    for (int t = off + 1; t <= off + DoneAt; t++) begin
      if (tx_log[t] !== exp_tx(t - off)) bad++;
    end
    check({tag, "_wave_mismatch_cycles"}, 32'(bad), 32'd0);
    decode(off + 1, off + DoneAt);
    check({tag, "_byte_count"}, 32'(dec_q.size()), 32'(NFr));
    for (int i = 0; i < NFr; i++) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < dec_q.size()) ? 32'(dec_q[i]) : 32'hDEAD, 32'(exp_bytes[i]));
    end
    check({tag, "_done_at"}, 32'(done_log[off + DoneAt]), 32'd1);
  endtask

  initial begin
    int cnt;
    int first_low;
    mem[0] = 32'h04030201;
    mem[1] = 32'hA5A500FF;
    mem[2] = 32'h0;
    mem[3] = 32'h0;

    // Reset held for three edges.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) cnt++;
    end
    check("idle_100_cycles", 32'(cnt), 32'd0);

    // Single transfer.
    capture(400, 1'b0, -1, -1, -1);
    first_low = -1;
    for (int t = 400; t >= 1; t--) if (tx_log[t] == 1'b0) first_low = t;
    check("first_tx_low", 32'(first_low), 32'd3);
    check_stream("run1", 0);
    cnt = 0;
    for (int t = 1; t <= 400; t++) if (done_log[t] == 1'b1) cnt++;
    check("run1_done_count", 32'(cnt), 32'd1);
    cnt = 0;
    for (int t = 1; t <= 400; t++) if (rden_log[t] == 1'b1) cnt++;
    check("run1_rd_en_count", 32'(cnt), 32'd2);
    check("run1_rd_en_c1", 32'(rden_log[1]), 32'd1);
    check("run1_rd_addr_c1", 32'(addr_log[1]), 32'd0);
    check("run1_rd_en_c163", 32'(rden_log[163]), 32'd1);
    check("run1_rd_addr_c163", 32'(addr_log[163]), 32'd1);
    check("run1_busy_c1", 32'(busy_log[1]), 32'd1);
    check("run1_busy_before_done", 32'(busy_log[DoneAt - 1]), 32'd1);
    check("run1_busy_at_done", 32'(busy_log[DoneAt]), 32'd0);

    // Extra start pulses mid-transfer are ignored.
    capture(400, 1'b0, 50, 200, -1);
    check_stream("run2", 0);
    cnt = 0;
    for (int t = 1; t <= 400; t++) if (done_log[t] == 1'b1) cnt++;
    check("run2_done_count", 32'(cnt), 32'd1);

    // Reset in the middle of the second byte's data bits.
    capture(200, 1'b0, -1, -1, 60);
    check("rst_mid_tx_c61", 32'(tx_log[61]), 32'd1);
    check("rst_mid_busy_c61", 32'(busy_log[61]), 32'd0);
    cnt = 0;
    for (int t = 1; t <= 200; t++) if (done_log[t] == 1'b1) cnt++;
    check("rst_mid_no_done", 32'(cnt), 32'd0);
    cnt = 0;
    for (int t = 61; t <= 200; t++) if (tx_log[t] !== 1'b1) cnt++;
    check("rst_mid_idle_after", 32'(cnt), 32'd0);
    capture(400, 1'b0, -1, -1, -1);
    check_stream("run3", 0);

    // start held high: the IDLE cycle after done relaunches at cycle DoneAt+2.
    capture(700, 1'b1, -1, -1, -1);
    check_stream("run4a", 0);
    check("run4_idle_after_done", 32'(rden_log[DoneAt + 1]), 32'd0);
    check("run4_refetch", 32'(rden_log[DoneAt + 2]), 32'd1);
    check("run4_refetch_addr", 32'(addr_log[DoneAt + 2]), 32'd0);
    check_stream("run4b", DoneAt + 1);
    cnt = 0;
    for (int t = 1; t <= 2 * DoneAt + 1; t++) if (done_log[t] == 1'b1) cnt++;
    check("run4_done_count", 32'(cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
